gonso_mul_regs: RTL and testbench



---
 rtl/gonso_mul_regs.sv | 216 +++++++++++++++++++++
 tb/tb_gonso_mul_regs.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gonso_mul_regs.sv
// gonso_mul_regs: Wishbone slave fronting NCH sequential shift-add multiplier channels.
// Optional overflow saturation (CTRL.OVF, RESULT forced to all-ones) when GONSO_MUL_SAT_EN is defined.
module gonso_mul_regs #(
    parameter int          NCH       = 2,
    parameter int          DW        = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3003_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq
);

`ifdef GONSO_MUL_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif
    localparam logic [5:0] CNT_INIT = 6'(DW);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [DW-1:0] merge_dw(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [DW-1:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    logic [7:0]     off_s;
    logic           hit_s;
    logic           valid_s;
    logic           wr_s;
    logic [31:0]    lane_mask_s;
    logic [NCH-1:0] status_clr_s;
    logic [NCH-1:0] ch_hit_s;
    logic [NCH-1:0] start_s;
    logic [NCH-1:0] fin_s;
    logic [NCH-1:0] ovf_step_s;
    logic [DW:0]    sum_s       [NCH];
    logic [31:0]    rd_s;
    ch_state_t      state_nxt_s [NCH];
    logic           unused_s;

    ch_state_t      state_r     [NCH];
    logic [DW-1:0]  op_a_r      [NCH];
    logic [DW-1:0]  op_b_r      [NCH];
    logic [DW-1:0]  result_r    [NCH];
    logic [DW-1:0]  acc_r       [NCH];
    logic [DW-1:0]  mcand_r     [NCH];
    logic [DW-1:0]  mplier_r    [NCH];
    logic [5:0]     cnt_r       [NCH];
    logic [NCH-1:0] done_r;
    logic [NCH-1:0] ovf_r;
    logic [NCH-1:0] lost_r;
    logic [NCH-1:0] irq_status_r;
    logic [NCH-1:0] irq_enable_r;
    logic           ack_r;
    logic [31:0]    dat_r;
    logic           irq_r;

    assign unused_s  = ^wbs_adr_i[1:0];
    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign irq       = irq_r;

    // Address decode, access qualification and per-channel step arithmetic
    always_comb begin
        off_s        = wbs_adr_i[7:0];
        hit_s        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        valid_s      = wbs_cyc_i && wbs_stb_i && hit_s && !ack_r;
        wr_s         = valid_s && wbs_we_i;
        lane_mask_s  = byte_mask(wbs_sel_i);
        status_clr_s = (wr_s && (off_s[7:2] == 6'h01)) ? (wbs_dat_i[NCH-1:0] & lane_mask_s[NCH-1:0])
                                                        : {NCH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            ch_hit_s[c]   = (off_s[7:4] == 4'(c + 1));
            start_s[c]    = wr_s && ch_hit_s[c] && (off_s[3:2] == 2'd0) && wbs_sel_i[0]
                            && wbs_dat_i[0] && (state_r[c] == ST_IDLE);
            fin_s[c]      = (state_r[c] == ST_RUN) && (cnt_r[c] == 6'd1);
            sum_s[c]      = {1'b0, acc_r[c]} + {1'b0, (mplier_r[c][0] ? mcand_r[c] : {DW{1'b0}})};
            // A partial product lands above DW either via a lost multiplicand bit or an adder carry
            ovf_step_s[c] = SAT_EN && mplier_r[c][0] && (sum_s[c][DW] || lost_r[c]);
        end
    end

    // Channel FSM next-state: IDLE -> RUN on accepted START, RUN -> IDLE on last step
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_nxt_s[c] = state_r[c];
            case (state_r[c])
                ST_IDLE: begin
                    if (start_s[c]) state_nxt_s[c] = ST_RUN;
                    else            state_nxt_s[c] = ST_IDLE;
                end
                ST_RUN: begin
                    if (fin_s[c]) state_nxt_s[c] = ST_IDLE;
                    else          state_nxt_s[c] = ST_RUN;
                end
                default: state_nxt_s[c] = ST_IDLE;
            endcase
        end
    end

    // Channel FSM state register
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) state_r[c] <= ST_IDLE;
            else     state_r[c] <= state_nxt_s[c];
        end
    end

    // Channel operand registers and shift-add datapath
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                op_a_r[c]   <= {DW{1'b0}};
                op_b_r[c]   <= {DW{1'b0}};
                result_r[c] <= {DW{1'b0}};
                acc_r[c]    <= {DW{1'b0}};
                mcand_r[c]  <= {DW{1'b0}};
                mplier_r[c] <= {DW{1'b0}};
                cnt_r[c]    <= 6'd0;
                done_r[c]   <= 1'b0;
                ovf_r[c]    <= 1'b0;
                lost_r[c]   <= 1'b0;
            end else begin
                if (wr_s && ch_hit_s[c] && (off_s[3:2] == 2'd1))
                    op_a_r[c] <= merge_dw(op_a_r[c], wbs_dat_i[DW-1:0], lane_mask_s[DW-1:0]);
                if (wr_s && ch_hit_s[c] && (off_s[3:2] == 2'd2))
                    op_b_r[c] <= merge_dw(op_b_r[c], wbs_dat_i[DW-1:0], lane_mask_s[DW-1:0]);
                if (start_s[c]) begin
                    mcand_r[c]  <= op_a_r[c];
                    mplier_r[c] <= op_b_r[c];
                    acc_r[c]    <= {DW{1'b0}};
                    cnt_r[c]    <= CNT_INIT;
                    done_r[c]   <= 1'b0;
                    ovf_r[c]    <= 1'b0;
                    lost_r[c]   <= 1'b0;
                end else if (state_r[c] == ST_RUN) begin
                    acc_r[c]    <= sum_s[c][DW-1:0];
                    mcand_r[c]  <= mcand_r[c] << 1;
                    mplier_r[c] <= mplier_r[c] >> 1;
                    cnt_r[c]    <= cnt_r[c] - 6'd1;
                    lost_r[c]   <= lost_r[c] | mcand_r[c][DW-1];
                    ovf_r[c]    <= ovf_r[c] | ovf_step_s[c];
                    if (fin_s[c]) begin
                        result_r[c] <= (ovf_r[c] | ovf_step_s[c]) ? {DW{1'b1}} : sum_s[c][DW-1:0];
                        done_r[c]   <= 1'b1;
                    end
                end
            end
        end
    end

    // Global interrupt status (completion beats a same-cycle clear) and enable registers
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status_r <= {NCH{1'b0}};
            irq_enable_r <= {NCH{1'b0}};
        end else begin
            irq_status_r <= (irq_status_r & ~status_clr_s) | fin_s;
            if (wr_s && (off_s[7:2] == 6'h02))
                irq_enable_r <= (irq_enable_r & ~lane_mask_s[NCH-1:0])
                              | (wbs_dat_i[NCH-1:0] & lane_mask_s[NCH-1:0]);
        end
    end

    // Read data multiplexer; unmapped offsets and absent channels return zero
    always_comb begin
        logic [31:0] ch_rd_v;
        rd_s    = 32'd0;
        ch_rd_v = 32'd0;
        case (off_s[7:2])
            6'h00:   rd_s = {8'hA5, 8'(NCH), 8'(DW), 8'h01};
            6'h01:   rd_s = 32'(irq_status_r);
            6'h02:   rd_s = 32'(irq_enable_r);
            default: begin
                for (int c = 0; c < NCH; c++) begin
                    case (off_s[3:2])
                        2'd0:    ch_rd_v = {28'd0, ovf_r[c], done_r[c], (state_r[c] == ST_RUN), 1'b0};
                        2'd1:    ch_rd_v = 32'(op_a_r[c]);
                        2'd2:    ch_rd_v = 32'(op_b_r[c]);
                        2'd3:    ch_rd_v = 32'(result_r[c]);
                        default: ch_rd_v = 32'd0;
                    endcase
                    rd_s = rd_s | (ch_hit_s[c] ? ch_rd_v : 32'd0);
                end
            end
        endcase
    end

    // Registered bus response and interrupt output
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
            irq_r <= 1'b0;
        end else begin
            ack_r <= valid_s;
            dat_r <= (valid_s && !wbs_we_i) ? rd_s : 32'd0;
            irq_r <= |(irq_status_r & irq_enable_r);
        end
    end

endmodule

// File: tb/tb_gonso_mul_regs.sv
// Self-checking bench for gonso_mul_regs (NCH=2, DW=32); expected read data is queued
// when each read is issued and popped when the acknowledge returns.
module tb_gonso_mul_regs;
    localparam int          NCH  = 2;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h3003_0100;
`ifdef GONSO_MUL_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_we_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        irq;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc     = 0;
    logic [31:0] exp_q[$];

    gonso_mul_regs #(.NCH(NCH), .DW(DW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_adr_i(wbs_adr_i), .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One bus transfer, waiting at most 8 edges for ack; returns just after an edge
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        acked = 1'b0; rdata = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                acked = 1'b1; rdata = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] dat);
        logic [31:0] d; logic a;
        xfer(1'b1, BASE + 32'(off), dat, 4'hF, d, a);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d, output logic a);
        xfer(1'b0, BASE + 32'(off), 32'd0, 4'hF, d, a);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rdat, e; logic ok;
        logic [7:0] offs [4];
        offs = '{8'h00, 8'h04, 8'h08, 8'h1C};
        rst = 1'b1; repeat (3) @(posedge clk); #1; rst = 1'b0;
        vec_cnt++;
        if (wbs_ack_o !== 1'b0 || irq !== 1'b0 || wbs_dat_o !== 32'd0) begin
            err_cnt++; $display("FAIL reset_outputs: got ack=%b irq=%b dat=%h exp 0/0/0", wbs_ack_o, irq, wbs_dat_o);
        end
        xfer(1'b1, 32'h3003_0208, 32'h3, 4'hF, rdat, ok);
        vec_cnt++;
        if (ok !== 1'b0) begin err_cnt++; $display("FAIL miss_write_ack: got ack=%b exp 0", ok); end
        xfer(1'b0, 32'h3003_0200, 32'h0, 4'hF, rdat, ok);
        vec_cnt++;
        if (ok !== 1'b0) begin err_cnt++; $display("FAIL miss_read_ack: got ack=%b exp 0", ok); end
        exp_q.push_back(32'hA502_2001); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);         exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(offs[i], rdat, ok);
            e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin
                err_cnt++; $display("FAIL reset_read off=%h: got %h ack=%b exp %h", offs[i], rdat, ok, e);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rdat, e; logic ok; int t0;
        logic [7:0] offs [3];
        wr(8'h14, 32'd7); wr(8'h18, 32'd6);
        wr(8'h10, 32'd1); t0 = cyc;
        exp_q.push_back(32'h2); rd(8'h10, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL busy_after_start: got %h exp %h", rdat, e); end
        wait_until(t0 + DW - 1);
        exp_q.push_back(32'h2); rd(8'h10, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL busy_last_cycle: got %h exp %h", rdat, e); end
        offs = '{8'h10, 8'h1C, 8'h04};
        exp_q.push_back(32'h4); exp_q.push_back(32'd42); exp_q.push_back(32'h1);
        for (int i = 0; i < 3; i++) begin
            rd(offs[i], rdat, ok); e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin
                err_cnt++; $display("FAIL mul_7x6 off=%h: got %h exp %h", offs[i], rdat, e);
            end
        end
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_disabled: got %b exp 0", irq); end
        wr(8'h04, 32'h1);
        wr(8'h10, 32'd1); t0 = cyc;
        exp_q.push_back(32'h2); rd(8'h10, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL done_cleared_on_start: got %h exp %h", rdat, e); end
        wait_until(t0 + DW);
        exp_q.push_back(32'h4); rd(8'h10, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL done_exact_cycle: got %h exp %h", rdat, e); end
        wr(8'h04, 32'h1);
    endtask

    task automatic test_irq();
        logic [31:0] rdat, e; logic ok; int t0;
        wr(8'h08, 32'h3);
        wr(8'h24, 32'd3); wr(8'h28, 32'd5);
        wr(8'h10, 32'd1); t0 = cyc;
        wr(8'h20, 32'd1);
        wait_until(t0 + DW);
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_same_cycle_as_status: got %b exp 0", irq); end
        @(posedge clk); #1;
        vec_cnt++;
        if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_rise: got %b exp 1", irq); end
        wait_until(t0 + DW + 4);
        wr(8'h04, 32'h1);
        exp_q.push_back(32'h2); rd(8'h04, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL status_after_w1c: got %h exp %h", rdat, e); end
        vec_cnt++;
        if (irq !== 1'b1) begin err_cnt++; $display("FAIL irq_held_by_ch1: got %b exp 1", irq); end
        exp_q.push_back(32'd15); rd(8'h2C, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL ch1_result: got %h exp %h", rdat, e); end
        wr(8'h04, 32'h2); @(posedge clk); #1;
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_fall: got %b exp 0", irq); end
        // clear landing on the completion edge: the set must win
        wr(8'h10, 32'd1); t0 = cyc;
        wait_until(t0 + DW - 1);
        wr(8'h04, 32'h1);
        exp_q.push_back(32'h1); rd(8'h04, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL set_beats_w1c: got %h exp %h", rdat, e); end
        wr(8'h04, 32'h3);
    endtask

    task automatic test_wrap();
        logic [31:0] rdat, e; logic ok; int t0;
        logic [31:0] a_v [3];
        logic [31:0] b_v [3];
        logic [31:0] r_v [3];
        logic [31:0] o_v [3];
        a_v = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_1234};
        b_v = '{32'd2,         32'h0001_0000, 32'h0000_0010};
        r_v = '{SAT ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, SAT ? 32'hFFFF_FFFF : 32'd0, 32'h0001_2340};
        o_v = '{SAT ? 32'hC : 32'h4, SAT ? 32'hC : 32'h4, 32'h4};
        for (int i = 0; i < 3; i++) begin
            wr(8'h24, a_v[i]); wr(8'h28, b_v[i]);
            wr(8'h20, 32'd1); t0 = cyc;
            wait_until(t0 + DW);
            exp_q.push_back(r_v[i]); exp_q.push_back(o_v[i]);
            rd(8'h2C, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin err_cnt++; $display("FAIL wrap_result[%0d]: got %h exp %h", i, rdat, e); end
            rd(8'h20, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin err_cnt++; $display("FAIL wrap_ctrl[%0d]: got %h exp %h", i, rdat, e); end
        end
        wr(8'h04, 32'h3);
    endtask

    task automatic test_busy_start();
        logic [31:0] rdat, e; logic ok; int t0;
        logic [7:0] offs [4];
        wr(8'h14, 32'd5); wr(8'h18, 32'd5);
        wr(8'h10, 32'd1); t0 = cyc;
        wr(8'h10, 32'd1);
        wr(8'h14, 32'd100);
        wait_until(t0 + DW);
        offs = '{8'h10, 8'h1C, 8'h14, 8'h04};
        exp_q.push_back(32'h4); exp_q.push_back(32'd25);
        exp_q.push_back(32'd100); exp_q.push_back(32'h1);
        for (int i = 0; i < 4; i++) begin
            rd(offs[i], rdat, ok); e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin
                err_cnt++; $display("FAIL start_during_run off=%h: got %h exp %h", offs[i], rdat, e);
            end
        end
    endtask

    task automatic test_map();
        logic [31:0] rdat, e; logic ok;
        logic [7:0] offs [5];
        wr(8'h28, 32'h0000_0002);
        xfer(1'b1, BASE + 32'h28, 32'h1122_3344, 4'b0010, rdat, ok);
        exp_q.push_back(32'h0000_3302); rd(8'h28, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL lane_sel_0010: got %h exp %h", rdat, e); end
        xfer(1'b1, BASE + 32'h28, 32'hAABB_CCDD, 4'b1001, rdat, ok);
        exp_q.push_back(32'hAA00_33DD); rd(8'h28, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL lane_sel_1001: got %h exp %h", rdat, e); end
        wr(8'h30, 32'd1); wr(8'h34, 32'hFFFF_FFFF); wr(8'h00, 32'h0);
        xfer(1'b1, BASE + 32'h04, 32'hF, 4'b0000, rdat, ok);
        vec_cnt++;
        if (ok !== 1'b1) begin err_cnt++; $display("FAIL sel0_write_ack: got %b exp 1", ok); end
        offs = '{8'h0C, 8'h30, 8'h34, 8'h04, 8'h00};
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'h1); exp_q.push_back(32'hA502_2001);
        for (int i = 0; i < 5; i++) begin
            rd(offs[i], rdat, ok); e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin
                err_cnt++; $display("FAIL map off=%h: got %h ack=%b exp %h", offs[i], rdat, ok, e);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] rdat, e; logic ok; int t0;
        logic [7:0] offs [4];
        wr(8'h14, 32'd5);
        wr(8'h10, 32'd1); t0 = cyc;
        wait_until(t0 + 10);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL irq_after_reset: got %b exp 0", irq); end
        offs = '{8'h10, 8'h1C, 8'h14, 8'h08};
        for (int i = 0; i < 4; i++) exp_q.push_back(32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(offs[i], rdat, ok); e = exp_q.pop_front(); vec_cnt++;
            if (!ok || rdat !== e) begin
                err_cnt++; $display("FAIL midrun_reset off=%h: got %h exp %h", offs[i], rdat, e);
            end
        end
        wr(8'h08, 32'h3);
        wait_until(t0 + DW + 10);
        vec_cnt++;
        if (irq !== 1'b0) begin err_cnt++; $display("FAIL no_irq_after_abort: got %b exp 0", irq); end
        exp_q.push_back(32'd0); rd(8'h04, rdat, ok); e = exp_q.pop_front(); vec_cnt++;
        if (!ok || rdat !== e) begin err_cnt++; $display("FAIL status_after_abort: got %h exp %h", rdat, e); end
    endtask

    initial begin
        rst = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; wbs_sel_i = 4'h0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_irq();
        test_wrap();
        test_busy_start();
        test_map();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
